fsquare_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision squarer, d = s*s, built as the inverse operation to the FPU's square-root unit. It uses a shift-add mantissa multiplier with a valid/ready handshake on both sides. It sits beside the pipelined FPU units and is used to check fsqrt results (fsqrt(x)² ≈ x) and as a low-area square path.

---
 rtl/fsquare_seq.sv | 130 +++++++++++++
 tb/tb_fsquare_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fsquare_seq.sv
// fsquare_seq: multi-cycle IEEE-754 single-precision squarer, d = s*s.
// Shift-add mantissa multiplier (BITS_PER_CYCLE multiplier bits per step),
// round-to-nearest-even, flush-to-zero on underflow, saturate to +inf.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid stays high and d stays
// stable in DONE until out_ready is seen.
module fsquare_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic [1:0]  state_dbg
);

  localparam int N = 24 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  e_q;
  logic [47:0] mc_q;   // multiplicand, pre-shifted to the weight of the next chunk
  logic [23:0] mr_q;   // multiplier bits not yet consumed, LSB first
  logic [47:0] p_q;
  logic [4:0]  cnt_q;
  logic [31:0] d_q;
  logic        out_valid_q;
  logic [31:0] d_next;

  // The operand sign never affects the square.
  logic unused_sign;
  assign unused_sign = s[31];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = MUL;
      MUL:   if (cnt_q == 5'(N - 1)) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add accumulation, result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e_q         <= 8'd0;
      mc_q        <= 48'd0;
      mr_q        <= 24'd0;
      p_q         <= 48'd0;
      cnt_q       <= 5'd0;
      d_q         <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          e_q   <= s[30:23];
          mc_q  <= {24'd0, 1'b1, s[22:0]};
          mr_q  <= {1'b1, s[22:0]};
          p_q   <= 48'd0;
          cnt_q <= 5'd0;
        end
        MUL: begin
          p_q   <= p_q + mc_q * {{(48 - BITS_PER_CYCLE){1'b0}}, mr_q[BITS_PER_CYCLE-1:0]};
          mc_q  <= mc_q << BITS_PER_CYCLE;
          mr_q  <= mr_q >> BITS_PER_CYCLE;
          cnt_q <= cnt_q + 5'd1;
        end
        ROUND: begin
          d_q         <= d_next;
          out_valid_q <= 1'b1;
        end
        DONE: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Normalise, round to nearest even, then apply special-case overrides.
  logic signed [9:0] e_norm, e_fin;
  logic [22:0]       frac;
  logic              guard, sticky;
  logic [23:0]       frac_inc;
  always_comb begin
    e_norm   = $signed({1'b0, e_q, 1'b0}) - 10'sd127;
    frac     = p_q[45:23];
    guard    = p_q[22];
    sticky   = |p_q[21:0];
    if (p_q[47]) begin
      e_norm = e_norm + 10'sd1;
      frac   = p_q[46:24];
      guard  = p_q[23];
      sticky = |p_q[22:0];
    end
    frac_inc = {1'b0, frac};
    if (guard && (sticky || frac[0])) frac_inc = frac_inc + 24'd1;
    e_fin = e_norm;
    if (frac_inc[23]) e_fin = e_norm + 10'sd1;
    d_next = {1'b0, e_fin[7:0], frac_inc[22:0]};
    if (e_q == 8'd0)             d_next = 32'h0000_0000;
    else if (e_q == 8'd255)      d_next = 32'h7F80_0000;
    else if (e_fin >= 10'sd255)  d_next = 32'h7F80_0000;
    else if (e_fin <= 10'sd0)    d_next = 32'h0000_0000;
  end

endmodule

// File: tb/tb_fsquare_seq.sv
// tb_fsquare_seq: scoreboard bench for fsquare_seq. Four instances with
// BITS_PER_CYCLE = 1, 2, 8, 12 each have their own handshake signals.
module tb_fsquare_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid  [4];
  logic [31:0] s_in      [4];
  logic        out_ready [4];
  logic        in_ready  [4];
  logic        out_valid [4];
  logic [31:0] d_out     [4];
  logic [1:0]  st_dbg    [4];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int a_cyc    = 0;
  logic [31:0] exp_q[$];

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 12;
    fsquare_seq #(.BITS_PER_CYCLE(BPC)) u_dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .s(s_in[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .d(d_out[g]),
      .state_dbg(st_dbg[g])
    );
  end

  function automatic int lat_of(int k);
    int bpc;
    bpc = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 12;
    return 24 / bpc + 1;
  endfunction

  // Reference: full multiply, remainder-based round-to-nearest-even.
  function automatic logic [31:0] fsq_model(logic [31:0] x);
    logic [47:0] m, p, q, r, half;
    logic [7:0]  e8;
    int ex, e, sh;
    ex = int'(x[30:23]);
    m  = {24'd0, 1'b1, x[22:0]};
    p  = m * m;
    if (ex == 0)   return 32'h0000_0000;
    if (ex == 255) return 32'h7F80_0000;
    e = 2 * ex - 127;
    if (p[47]) begin sh = 24; e = e + 1; end
    else sh = 23;
    q    = p >> sh;
    r    = p & ((48'd1 << sh) - 48'd1);
    half = 48'd1 << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 48'd1;
    if (q[24]) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return 32'h7F80_0000;
    if (e <= 0)   return 32'h0000_0000;
    e8 = e[7:0];
    return {1'b0, e8, q[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Drive one operand on instance k and record the accepting edge.
  task automatic issue(input int k, input logic [31:0] val, input logic [31:0] expv);
    int guard = 0;
    while (!in_ready[k] && guard < 300) begin @(negedge clk); guard++; end
    if (!in_ready[k]) check("issue_timeout", {31'd0, in_ready[k]}, 32'd1);
    in_valid[k] = 1'b1;
    s_in[k]     = val;
    exp_q.push_back(expv);
    @(negedge clk);
    a_cyc       = cyc;
    in_valid[k] = 1'b0;
    s_in[k]     = $urandom;
  endtask

  // Wait for out_valid, check latency and data; completes the transfer if out_ready is high.
  task automatic collect(input int k, input string tag, output logic [31:0] expv);
    int guard = 0;
    int lat;
    expv = 32'hDEAD_BEEF;
    while (!out_valid[k] && guard < 300) begin @(negedge clk); guard++; end
    if (!out_valid[k]) begin
      check({tag, "_timeout"}, {31'd0, out_valid[k]}, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    lat = cyc - a_cyc;
    check({tag, "_lat"}, lat, lat_of(k));
    check({tag, "_rdy_busy"}, {31'd0, in_ready[k]}, 32'd0);
    expv = exp_q.pop_front();
    check(tag, d_out[k], expv);
    if (out_ready[k]) begin
      @(negedge clk);
      check({tag, "_ovalid_drop"}, {31'd0, out_valid[k]}, 32'd0);
      check({tag, "_irdy_back"}, {31'd0, in_ready[k]}, 32'd1);
    end
  endtask

  // Abort an operation in MUL with reset, then run a clean one.
  task automatic reset_mid(input int k);
    logic [31:0] e;
    int mid;
    int stale = 0;
    issue(k, 32'h4040_0000, 32'h4110_0000);
    mid = (lat_of(k) - 1 >= 5) ? 5 : 1;
    repeat (mid - 1) @(negedge clk);
    rstn = 1'b0;
    #1;
    check($sformatf("rst%0d_ovalid", k), {31'd0, out_valid[k]}, 32'd0);
    check($sformatf("rst%0d_d", k), d_out[k], 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    void'(exp_q.pop_back());
    repeat (40) begin
      @(negedge clk);
      if (out_valid[k]) stale++;
    end
    check($sformatf("rst%0d_stale", k), stale, 32'd0);
    issue(k, 32'h4040_0000, 32'h4110_0000);
    collect(k, $sformatf("rst%0d_after", k), e);
  endtask

  localparam int NV = 12;
  localparam logic [31:0] VEC_S [NV] = '{
    32'h4040_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'hC000_0000,
    32'h3F80_0001, 32'h3FFF_FFFF, 32'h3FB5_04F3, 32'h5F00_0000,
    32'h5F80_0000, 32'h1F80_0000, 32'h0000_0001, 32'h7FC0_0000};
  localparam logic [31:0] VEC_D [NV] = '{
    32'h4110_0000, 32'h4010_0000, 32'h3F80_0000, 32'h4080_0000,
    32'h3F80_0002, 32'h407F_FFFE, 32'h3FFF_FFFF, 32'h7E80_0000,
    32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000};

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main sequence.
  initial begin
    logic [31:0] e, x;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; s_in[k] = 32'd0; out_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("reset_ovalid", {31'd0, out_valid[0]}, 32'd0);
    check("reset_d", d_out[0], 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_irdy", {31'd0, in_ready[0]}, 32'd1);
    check("reset_state", {30'd0, st_dbg[0]}, 32'd0);

    // Directed vectors.
    for (int i = 0; i < NV; i++) begin
      issue(0, VEC_S[i], VEC_D[i]);
      collect(0, $sformatf("vec%0d", i), e);
    end

    // Random operands checked against the reference model.
    for (int i = 0; i < 8; i++) begin
      x = {$urandom_range(1, 0), 8'($urandom_range(60, 190)), 23'($urandom)};
      issue(0, x, fsq_model(x));
      collect(0, $sformatf("rnd%0d", i), e);
    end

    // Back-pressure: result held for 10 cycles.
    out_ready[0] = 1'b0;
    issue(0, 32'h3FC0_0000, 32'h4010_0000);
    collect(0, "hold", e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_d%0d", i), d_out[0], e);
      check($sformatf("hold_v%0d", i), {31'd0, out_valid[0]}, 32'd1);
      check($sformatf("hold_r%0d", i), {31'd0, in_ready[0]}, 32'd0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("hold_release_v", {31'd0, out_valid[0]}, 32'd0);
    check("hold_release_r", {31'd0, in_ready[0]}, 32'd1);

    // in_valid pulse during MUL is ignored.
    issue(0, 32'h4040_0000, 32'h4110_0000);
    repeat (3) @(negedge clk);
    in_valid[0] = 1'b1; s_in[0] = 32'h4000_0000;
    @(negedge clk);
    in_valid[0] = 1'b0;
    collect(0, "ignore", e);

    // Reset mid-operation.
    reset_mid(0);

    // Parameter sweep: basic case and reset case on the other widths.
    for (int k = 1; k < 4; k++) begin
      issue(k, 32'h4040_0000, 32'h4110_0000);
      collect(k, $sformatf("sweep%0d_basic", k), e);
      reset_mid(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
